// File: rtl/scoreboard_alu.sv
// rtl/scoreboard_alu.sv - latency-matched reference scoreboard for the RV32I ALU bench
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } ALUSel_e;
endpackage

module scoreboard_alu
    import alu_pkg::*;
#(
    parameter int LATENCY    = 0,
    parameter int CNT_W      = 32,
    parameter int NUM_CHECKS = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_check_en,
    input  logic [31:0]      i_operand_a,
    input  logic [31:0]      i_operand_b,
    input  ALUSel_e          i_alu_op,
    input  logic [31:0]      i_alu_data,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic [CNT_W-1:0] o_skip_cnt,
    output logic             o_mismatch,
    output logic             o_done,
    output logic             o_err_valid,
    output ALUSel_e          o_err_op,
    output logic [31:0]      o_err_a,
    output logic [31:0]      o_err_b,
    output logic [31:0]      o_err_exp,
    output logic [31:0]      o_err_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   DONE_AT = (CNT_W+1)'(NUM_CHECKS);

    logic        chk_valid;
    logic [31:0] chk_a;
    logic [31:0] chk_b;
    ALUSel_e     chk_op;

    generate
        if (LATENCY > 0) begin : gen_delay
            logic        dl_valid [LATENCY];
            logic [31:0] dl_a     [LATENCY];
            logic [31:0] dl_b     [LATENCY];
            ALUSel_e     dl_op    [LATENCY];

            // Shift the snooped tuple so it lines up with the DUT result; only valid bits need reset
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LATENCY; i++) dl_valid[i] <= 1'b0;
                end else begin
                    dl_valid[0] <= i_check_en;
                    for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
                end
                dl_a[0]  <= i_operand_a;
                dl_b[0]  <= i_operand_b;
                dl_op[0] <= i_alu_op;
                for (int i = 1; i < LATENCY; i++) begin
                    dl_a[i]  <= dl_a[i-1];
                    dl_b[i]  <= dl_b[i-1];
                    dl_op[i] <= dl_op[i-1];
                end
            end

            assign chk_valid = dl_valid[LATENCY-1];
            assign chk_a     = dl_a[LATENCY-1];
            assign chk_b     = dl_b[LATENCY-1];
            assign chk_op    = dl_op[LATENCY-1];
        end else begin : gen_live
            assign chk_valid = i_check_en;
            assign chk_a     = i_operand_a;
            assign chk_b     = i_operand_b;
            assign chk_op    = i_alu_op;
        end
    endgenerate

    logic [31:0] exp_res;
    logic        supported;

    // Golden RV32I ALU model on the delayed tuple; unknown encodings flagged as unsupported
    always_comb begin
        exp_res   = 32'h0;
        supported = 1'b1;
        case (chk_op)
            ALU_ADD:  exp_res = chk_a + chk_b;
            ALU_SUB:  exp_res = chk_a - chk_b;
            ALU_XOR:  exp_res = chk_a ^ chk_b;
            ALU_OR:   exp_res = chk_a | chk_b;
            ALU_AND:  exp_res = chk_a & chk_b;
            ALU_SLL:  exp_res = chk_a << chk_b[4:0];
            ALU_SRL:  exp_res = chk_a >> chk_b[4:0];
            ALU_SRA:  exp_res = $signed(chk_a) >>> chk_b[4:0];
            ALU_SLT:  exp_res = {31'h0, $signed(chk_a) < $signed(chk_b)};
            ALU_SLTU: exp_res = {31'h0, chk_a < chk_b};
            default:  supported = 1'b0;
        endcase
    end

    logic             fire;
    logic             pass_hit;
    logic             fail_hit;
    logic             skip_hit;
    logic [CNT_W-1:0] pass_nxt;
    logic [CNT_W-1:0] fail_nxt;
    logic [CNT_W:0]   checked_nxt;

    // Classify this edge's check; case equality so an X/Z DUT result counts as a failure
    always_comb begin
        fire        = chk_valid && !o_done;
        pass_hit    = fire && supported && (i_alu_data === exp_res);
        fail_hit    = fire && supported && !(i_alu_data === exp_res);
        skip_hit    = fire && !supported;
        pass_nxt    = (pass_hit && o_pass_cnt != CNT_MAX) ? o_pass_cnt + CNT_W'(1) : o_pass_cnt;
        fail_nxt    = (fail_hit && o_fail_cnt != CNT_MAX) ? o_fail_cnt + CNT_W'(1) : o_fail_cnt;
        checked_nxt = {1'b0, pass_nxt} + {1'b0, fail_nxt};
    end

    // Statistics, mismatch pulse, done flag and the frozen first-error record
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pass_cnt  <= '0;
            o_fail_cnt  <= '0;
            o_skip_cnt  <= '0;
            o_mismatch  <= 1'b0;
            o_done      <= 1'b0;
            o_err_valid <= 1'b0;
            o_err_op    <= ALU_ADD;
            o_err_a     <= 32'h0;
            o_err_b     <= 32'h0;
            o_err_exp   <= 32'h0;
            o_err_got   <= 32'h0;
        end else begin
            o_mismatch <= fail_hit;
            o_pass_cnt <= pass_nxt;
            o_fail_cnt <= fail_nxt;
            if (skip_hit && o_skip_cnt != CNT_MAX) o_skip_cnt <= o_skip_cnt + CNT_W'(1);
            if ((pass_hit || fail_hit) && checked_nxt == DONE_AT) o_done <= 1'b1;
            if (fail_hit && !o_err_valid) begin
                o_err_valid <= 1'b1;
                o_err_op    <= chk_op;
                o_err_a     <= chk_a;
                o_err_b     <= chk_b;
                o_err_exp   <= exp_res;
                o_err_got   <= i_alu_data;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_alu.sv
// tb/tb_scoreboard_alu.sv - directed self-checking bench for scoreboard_alu
module tb_scoreboard_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    ALUSel_e     op;
    logic        en0, en2, en4;
    logic [31:0] d0, d2, d4;

    logic [31:0] pass0, fail0, skip0, ea0, eb0, eexp0, egot0;
    logic [31:0] pass2, fail2, skip2, ea2, eb2, eexp2, egot2;
    logic [31:0] pass4, fail4, skip4, ea4, eb4, eexp4, egot4;
    logic        mm0, done0, ev0, mm2, done2, ev2, mm4, done4, ev4;
    ALUSel_e     eop0, eop2, eop4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scoreboard_alu #(.LATENCY(0), .CNT_W(32), .NUM_CHECKS(1000)) u_lat0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_check_en(en0), .i_operand_a(a), .i_operand_b(b),
        .i_alu_op(op), .i_alu_data(d0), .o_pass_cnt(pass0), .o_fail_cnt(fail0), .o_skip_cnt(skip0),
        .o_mismatch(mm0), .o_done(done0), .o_err_valid(ev0), .o_err_op(eop0), .o_err_a(ea0),
        .o_err_b(eb0), .o_err_exp(eexp0), .o_err_got(egot0));

    scoreboard_alu #(.LATENCY(2), .CNT_W(32), .NUM_CHECKS(1000)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_check_en(en2), .i_operand_a(a), .i_operand_b(b),
        .i_alu_op(op), .i_alu_data(d2), .o_pass_cnt(pass2), .o_fail_cnt(fail2), .o_skip_cnt(skip2),
        .o_mismatch(mm2), .o_done(done2), .o_err_valid(ev2), .o_err_op(eop2), .o_err_a(ea2),
        .o_err_b(eb2), .o_err_exp(eexp2), .o_err_got(egot2));

    scoreboard_alu #(.LATENCY(0), .CNT_W(32), .NUM_CHECKS(4)) u_done4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_check_en(en4), .i_operand_a(a), .i_operand_b(b),
        .i_alu_op(op), .i_alu_data(d4), .o_pass_cnt(pass4), .o_fail_cnt(fail4), .o_skip_cnt(skip4),
        .o_mismatch(mm4), .o_done(done4), .o_err_valid(ev4), .o_err_op(eop4), .o_err_a(ea4),
        .o_err_b(eb4), .o_err_exp(eexp4), .o_err_got(egot4));

    // one rising edge, then settle on the falling edge where outputs are sampled and inputs driven
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input ALUSel_e o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en0 = 0; en2 = 0; en4 = 0; d0 = 0; d2 = 0; d4 = 0;
        drive(ALU_SUB, 32'h1234, 32'h5678);
        step();
        n_assert++; if (pass0 !== 32'd0) begin n_fail++; $display("FAIL reset_pass0 got %0h exp 0", pass0); end
        n_assert++; if (fail0 !== 32'd0) begin n_fail++; $display("FAIL reset_fail0 got %0h exp 0", fail0); end
        n_assert++; if (skip0 !== 32'd0) begin n_fail++; $display("FAIL reset_skip0 got %0h exp 0", skip0); end
        n_assert++; if ({mm0, done0, ev0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0 got %b exp 000", {mm0, done0, ev0}); end
        n_assert++; if (eop0 !== ALU_ADD) begin n_fail++; $display("FAIL reset_err_op got %0d exp %0d", eop0, ALU_ADD); end
        n_assert++; if ({ea0, eb0, eexp0, egot0} !== 128'h0) begin n_fail++; $display("FAIL reset_err_rec got %h exp 0", {ea0, eb0, eexp0, egot0}); end
        n_assert++; if ({pass2, fail2, pass4, fail4} !== 128'h0) begin n_fail++; $display("FAIL reset_other_cnt got %h exp 0", {pass2, fail2, pass4, fail4}); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        en0 = 1; drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1); d0 = 32'h0;
        step();
        n_assert++; if (pass0 !== 32'd1) begin n_fail++; $display("FAIL add_pass got %0d exp 1", pass0); end
        n_assert++; if (mm0 !== 1'b0) begin n_fail++; $display("FAIL add_mismatch got %b exp 0", mm0); end
        drive(ALU_SUB, 32'h0, 32'h1); d0 = 32'hFFFF_FFFF;
        step();
        n_assert++; if (pass0 !== 32'd2) begin n_fail++; $display("FAIL sub_pass got %0d exp 2", pass0); end
        n_assert++; if (fail0 !== 32'd0) begin n_fail++; $display("FAIL sub_fail got %0d exp 0", fail0); end
        en0 = 0;
    endtask

    task automatic test_shift_cmp();
        en0 = 1; drive(ALU_SRA, 32'h8000_0000, 32'h0000_0021); d0 = 32'hC000_0000;
        step();
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1); d0 = 32'h1;
        step();
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1); d0 = 32'h0;
        step();
        en0 = 0;
        n_assert++; if (pass0 !== 32'd5) begin n_fail++; $display("FAIL shift_cmp_pass got %0d exp 5", pass0); end
        n_assert++; if (fail0 !== 32'd0) begin n_fail++; $display("FAIL shift_cmp_fail got %0d exp 0", fail0); end
    endtask

    task automatic test_fault();
        en0 = 1; drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); d0 = 32'h0;
        step();
        n_assert++; if (mm0 !== 1'b1) begin n_fail++; $display("FAIL fault_pulse got %b exp 1", mm0); end
        n_assert++; if (fail0 !== 32'd1) begin n_fail++; $display("FAIL fault_fail got %0d exp 1", fail0); end
        n_assert++; if (ev0 !== 1'b1) begin n_fail++; $display("FAIL fault_err_valid got %b exp 1", ev0); end
        n_assert++; if (eexp0 !== 32'hF000_F000) begin n_fail++; $display("FAIL fault_err_exp got %h exp f000f000", eexp0); end
        n_assert++; if (egot0 !== 32'h0) begin n_fail++; $display("FAIL fault_err_got got %h exp 0", egot0); end
        n_assert++; if (eop0 !== ALU_AND) begin n_fail++; $display("FAIL fault_err_op got %0d exp %0d", eop0, ALU_AND); end
        n_assert++; if ({ea0, eb0} !== {32'hF0F0_F0F0, 32'hFF00_FF00}) begin n_fail++; $display("FAIL fault_err_ab got %h %h", ea0, eb0); end
        en0 = 0;
        step();
        n_assert++; if (mm0 !== 1'b0) begin n_fail++; $display("FAIL fault_pulse_once got %b exp 0", mm0); end
        en0 = 1; drive(ALU_ADD, 32'h1, 32'h1); d0 = 32'h5;
        step();
        n_assert++; if ({mm0, fail0} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL b2b_first got %b/%0d exp 1/2", mm0, fail0); end
        drive(ALU_SUB, 32'h5, 32'h1); d0 = 32'h0;
        step();
        n_assert++; if ({mm0, fail0} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL b2b_second got %b/%0d exp 1/3", mm0, fail0); end
        n_assert++; if ({eexp0, ea0, eop0} !== {32'hF000_F000, 32'hF0F0_F0F0, ALU_AND}) begin n_fail++; $display("FAIL record_frozen got exp %h a %h", eexp0, ea0); end
        en0 = 0;
        step();
        n_assert++; if (mm0 !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end got %b exp 0", mm0); end
    endtask

    task automatic test_latency2();
        // correctly delayed DUT: results appear two edges after their operands
        en2 = 1; drive(ALU_ADD, 32'd3, 32'd4); d2 = 32'h0;
        step();
        n_assert++; if ({pass2, fail2} !== 64'h0) begin n_fail++; $display("FAIL lat2_early got %0d/%0d exp 0/0", pass2, fail2); end
        en2 = 0; drive(ALU_XOR, 32'hAAAA, 32'h5555); d2 = 32'h0;
        step();
        en2 = 1; drive(ALU_SUB, 32'd20, 32'd5); d2 = 32'd7;
        step();
        n_assert++; if ({pass2, fail2} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lat2_first got %0d/%0d exp 1/0", pass2, fail2); end
        en2 = 0; d2 = 32'hDEAD;
        step();
        n_assert++; if ({pass2, fail2} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lat2_gap got %0d/%0d exp 1/0", pass2, fail2); end
        d2 = 32'd15;
        step();
        n_assert++; if ({pass2, fail2} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL lat2_second got %0d/%0d exp 2/0", pass2, fail2); end
        d2 = 32'hBEEF;
        step(); step();
        n_assert++; if ({pass2, fail2} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL lat2_idle got %0d/%0d exp 2/0", pass2, fail2); end
        // undelayed DUT: each result arrives two edges too early
        en2 = 1; drive(ALU_ADD, 32'd3, 32'd4); d2 = 32'd7;
        step();
        en2 = 0; drive(ALU_XOR, 32'hAAAA, 32'h5555); d2 = 32'hFFFF;
        step();
        en2 = 1; drive(ALU_SUB, 32'd20, 32'd5); d2 = 32'd15;
        step();
        n_assert++; if (fail2 !== 32'd1) begin n_fail++; $display("FAIL undelayed_first got %0d exp 1", fail2); end
        en2 = 0; drive(ALU_ADD, 32'd0, 32'd0); d2 = 32'h0;
        step(); step();
        n_assert++; if ({pass2, fail2} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL undelayed_second got %0d/%0d exp 2/2", pass2, fail2); end
        step(); step();
    endtask

    task automatic test_done();
        for (int i = 1; i <= 6; i++) begin
            en4 = 1; drive(ALU_ADD, 32'(i), 32'(i));
            d4 = (i == 5) ? 32'hDEAD_BEEF : 32'(2 * i);
            step();
            if (i == 3) begin
                n_assert++; if ({done4, pass4} !== {1'b0, 32'd3}) begin n_fail++; $display("FAIL done_pre got %b/%0d exp 0/3", done4, pass4); end
            end
            if (i == 4) begin
                n_assert++; if ({done4, pass4} !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL done_set got %b/%0d exp 1/4", done4, pass4); end
            end
            if (i == 5) begin
                n_assert++; if ({mm4, fail4} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL done_frozen_fail got %b/%0d exp 0/0", mm4, fail4); end
            end
        end
        en4 = 0;
        n_assert++; if ({done4, pass4, ev4} !== {1'b1, 32'd4, 1'b0}) begin n_fail++; $display("FAIL done_final got %b/%0d/%b exp 1/4/0", done4, pass4, ev4); end
    endtask

    task automatic test_mid_reset();
        en2 = 1; drive(ALU_ADD, 32'd1, 32'd1); d2 = 32'h0;
        step();
        drive(ALU_ADD, 32'd2, 32'd2);
        step();
        rst_n = 1'b0; en2 = 0;
        step();
        n_assert++; if ({pass2, fail2, pass0, fail0} !== 128'h0) begin n_fail++; $display("FAIL midreset_cnt got %0d/%0d/%0d/%0d exp 0", pass2, fail2, pass0, fail0); end
        n_assert++; if ({ev0, done4} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags got %b exp 00", {ev0, done4}); end
        rst_n = 1'b1; d2 = 32'h0BAD;
        step();
        n_assert++; if ({mm2, pass2, fail2} !== 65'h0) begin n_fail++; $display("FAIL midreset_inflight got %b/%0d/%0d exp 0", mm2, pass2, fail2); end
        step();
        n_assert++; if ({pass2, fail2} !== 64'h0) begin n_fail++; $display("FAIL midreset_drain got %0d/%0d exp 0/0", pass2, fail2); end
    endtask

    task automatic test_illegal_op();
        en0 = 1; drive(ALUSel_e'(4'hF), 32'h1, 32'h2); d0 = 32'h3;
        step();
        en0 = 0;
        n_assert++; if (skip0 !== 32'd1) begin n_fail++; $display("FAIL illegal_skip got %0d exp 1", skip0); end
        n_assert++; if ({mm0, pass0, fail0} !== 65'h0) begin n_fail++; $display("FAIL illegal_nocmp got %b/%0d/%0d exp 0", mm0, pass0, fail0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_shift_cmp();
        test_fault();
        test_latency2();
        test_done();
        test_mid_reset();
        test_illegal_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
